// File: rtl/x_corr_feeder.sv
// Window buffer that loads LENGTH I/Q sample pairs and streams them to x_corr over AXI-Stream.
// Optional X_CORR_FEEDER_REPLAY_EN: after a stream, return to FULL so each start replays the window.
module x_corr_feeder #(
  parameter int unsigned SAMPLE_BITS         = 8,
  parameter int unsigned LENGTH              = 16,
  parameter int unsigned LENGTH_COUNTER_BITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [SAMPLE_BITS-1:0]         load_xi,
  input  logic [SAMPLE_BITS-1:0]         load_xq,
  input  logic [SAMPLE_BITS-1:0]         load_yi,
  input  logic [SAMPLE_BITS-1:0]         load_yq,
  input  logic                           start,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [SAMPLE_BITS-1:0]         xi,
  output logic [SAMPLE_BITS-1:0]         xq,
  output logic [SAMPLE_BITS-1:0]         yi,
  output logic [SAMPLE_BITS-1:0]         yq,
  output logic                           m_axis_tlast,
  output logic [LENGTH_COUNTER_BITS:0]   index,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned PTR_W  = LENGTH_COUNTER_BITS + 1;
  localparam int unsigned ADDR_W = LENGTH_COUNTER_BITS;
  localparam int unsigned WORD_W = 4 * SAMPLE_BITS;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LENGTH - 1);
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_STREAM,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   rd_inc;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               load_fire;
  logic               out_fire;

  logic [WORD_W-1:0]  buffer [LENGTH];

  assign load_fire = load_valid & ready_q;
  assign out_fire  = tvalid_q & m_axis_tready;
  assign rd_inc    = rd_ptr_q + PTR_W'(1);

  // Sample storage; deliberately not reset, contents are don't-care until reloaded
  always_ff @(posedge clk) begin
    if (load_fire) begin
      buffer[wr_ptr_q[ADDR_W-1:0]] <= {load_xi, load_xq, load_yi, load_yq};
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      word_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      word_q   <= word_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state and next-output logic; outputs are computed from the next state so they stay registered
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    word_d   = word_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_fire) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_fire) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == LAST_PTR) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (start) begin
          state_d  = S_STREAM;
          rd_ptr_d = '0;
          word_d   = buffer[0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      S_STREAM: begin
        if (out_fire) begin
          if (tlast_q) begin
            state_d  = S_DONE;
            rd_ptr_d = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_inc;
            word_d   = buffer[rd_inc[ADDR_W-1:0]];
            tlast_d  = (rd_inc == LAST_PTR);
          end
        end
      end
      S_DONE: begin
`ifdef X_CORR_FEEDER_REPLAY_EN
        state_d  = S_FULL;
`else
        state_d  = S_IDLE;
        wr_ptr_d = '0;
`endif
      end
      default: begin
        state_d  = S_IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase

    busy_d  = (state_d == S_STREAM);
    ready_d = ((state_d == S_IDLE) || (state_d == S_LOAD)) && (wr_ptr_d < FULL_PTR);
  end

  assign load_ready    = ready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign index         = rd_ptr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign xi            = word_q[4*SAMPLE_BITS-1 -: SAMPLE_BITS];
  assign xq            = word_q[3*SAMPLE_BITS-1 -: SAMPLE_BITS];
  assign yi            = word_q[2*SAMPLE_BITS-1 -: SAMPLE_BITS];
  assign yq            = word_q[SAMPLE_BITS-1 -: SAMPLE_BITS];

endmodule

// File: doc/x_corr_feeder.md
X_CORR_FEEDER -- requirements
Module: x_corr_feeder

Interface
REQ-001 Parameter SAMPLE_BITS, default 8: width of each of xi, xq, yi, yq (signed two's complement).
REQ-002 Parameter LENGTH, default 16: samples per correlation window (>= 2).
REQ-003 Parameter LENGTH_COUNTER_BITS, default 4: ceil(log2(LENGTH)).
REQ-004 Ports, as name, direction, width, meaning:
  - clk  in  1  sole clock; all state on rising edge.
  - reset  in  1  asynchronous, active-high reset.
  - load_valid  in  1  load sample present.
  - load_ready  out  1  buffer can accept a load sample.
  - load_xi, load_xq, load_yi, load_yq  in  SAMPLE_BITS each  load sample.
  - start  in  1  request to stream the buffered window.
  - m_axis_tvalid  out  1  output sample valid.
  - m_axis_tready  in  1  downstream x_corr accepts the sample.
  - xi, xq, yi, yq  out  SAMPLE_BITS each  output sample.
  - m_axis_tlast  out  1  marks sample LENGTH-1.
  - index  out  LENGTH_COUNTER_BITS+1  position of the current output sample.
  - busy  out  1  high in STREAM.
  - done  out  1  one-cycle pulse after the final handshake.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, FULL, STREAM and DONE.
REQ-006 A load handshake SHALL be load_valid and load_ready both high on a clk edge.
  - The sample is written to buffer[wr_ptr] and wr_ptr increments.
  - The first handshake moves IDLE to LOAD.
REQ-007 load_ready SHALL be high only in IDLE and LOAD with wr_ptr < LENGTH.
REQ-008 The handshake writing entry LENGTH-1 SHALL move LOAD to FULL.
REQ-009 Loads in FULL, STREAM and DONE SHALL be ignored, with load_ready low.
REQ-010 Streaming SHALL start only from FULL:
  - start in FULL moves to STREAM with rd_ptr = 0.
  - start in any other state SHALL be ignored.
REQ-011 m_axis_tvalid SHALL rise on the first cycle after the start edge, presenting buffer[0]. Start-to-valid latency is 1 cycle.
REQ-012 Output handshake and ordering:
  - A handshake is m_axis_tvalid and m_axis_tready both high on an edge.
  - Each handshake SHALL advance rd_ptr by 1.
  - Samples SHALL be emitted in load order; none SHALL be duplicated or dropped.
REQ-013 While m_axis_tvalid is high and m_axis_tready is low, xi/xq/yi/yq/m_axis_tlast/index SHALL hold stable. m_axis_tvalid SHALL NOT deassert before its handshake.
REQ-014 With m_axis_tready held high, one sample SHALL transfer per cycle with no bubbles. LENGTH samples take LENGTH cycles.
REQ-015 m_axis_tlast SHALL be high only while rd_ptr == LENGTH-1. index SHALL equal rd_ptr zero-extended.
REQ-016 The handshake on the tlast sample SHALL move STREAM to DONE:
  - m_axis_tvalid drops on the next cycle.
  - done is high for exactly that one cycle.
  - The next state is IDLE.
REQ-017 busy SHALL equal (state == STREAM).
REQ-018 In IDLE, xi/xq/yi/yq SHALL hold their last driven values. Downstream qualifies data only by m_axis_tvalid.

Reset
REQ-019 reset high SHALL immediately force the following, including mid-LOAD or mid-STREAM:
  - state = IDLE, wr_ptr = rd_ptr = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, done = 0, busy = 0.
  - xi = xq = yi = yq = 0, index = 0.
  - load_ready = 1 from the first edge after reset release.
REQ-020 Buffer contents SHALL NOT be reset; they are treated as invalid after reset.

Configuration
REQ-021 Macro X_CORR_FEEDER_REPLAY_EN selects the DONE-to-IDLE behaviour.
  - Defined: DONE SHALL return to FULL instead of IDLE, with the buffer retained. Each further start replays the identical window. A new window requires reset.
  - Undefined: DONE SHALL return to IDLE with wr_ptr = 0. start after DONE is ignored until LENGTH new samples are loaded.

Verification
REQ-023 The bench SHALL cover these directed scenarios (LENGTH=16, SAMPLE_BITS=8):
  - Load samples (k, -k, 2k, -2k) for k = 0..15, start, tready held high -> 16 consecutive valid cycles with matching values; tlast only at index 15; done one cycle after; load_ready high again (REPLAY undefined).
  - Same window, tready toggled 1,0,0,1 repeating -> outputs held stable while tready is low; order 0..15 preserved; exactly 16 handshakes.
  - 17th load_valid after 16 loads -> load_ready low; sample 16 never emitted. start after only 10 loads -> no m_axis_tvalid.
  - reset asserted after 5 output handshakes -> m_axis_tvalid/busy low at once; state IDLE; second start ignored until 16 reloads.
  - REPLAY defined: two starts after one load -> two identical 16-sample streams; start during STREAM ignored; load_ready stays low.
